i281_boot_imem: RTL and testbench
=================================

// Module: i281_boot_imem
// PURPOSE
//  Parametrised, field-reloadable instruction memory for the i281 CPU; replaces fixed hardcoded BIOS word banks.
//  Powers up holding a compile-time default image, serves one instruction word per cycle to the fetch stage,
//  and accepts a byte-serial program download (valid/ready) with trailing checksum while the CPU is held.
// PARAMETERS
//  WORD_W      16                 instruction width in bits (must be even: loaded as hi byte then lo byte)
//  DEPTH       32                 number of instruction words
//  INIT_IMAGE  {DEPTH*WORD_W{1'b0}}  reset image; word i = INIT_IMAGE[i*WORD_W +: WORD_W]
//  ADDR_W      localparam = $clog2(DEPTH), minimum 1
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  pc_addr     in   ADDR_W   fetch address from PC
//  instr_out   out  WORD_W   registered instruction word
//  cpu_hold    out  1        high while a download is in progress; CPU must not advance PC
//  load_start  in   1        request download (sampled only in RUN)
//  load_data   in   8        download byte
//  load_valid  in   1        load_data valid
//  load_ready  out  1        block accepts byte this cycle (handshake = valid & ready)
//  load_done   out  1        one-cycle pulse when download ends
//  load_err    out  1        sticky: last download checksum mismatched; cleared by next load_start
// BEHAVIOUR
//  Reset (async, any state): mem <= INIT_IMAGE, state RUN, instr_out 0, cpu_hold 0, load_ready 0,
//   load_done 0, load_err 0, word ptr 0, checksum 0. Reset mid-download discards it and restores INIT_IMAGE.
//  States: RUN, LOAD_HI, LOAD_LO, LOAD_CHK.
//  RUN: instr_out <= mem[pc_addr] every cycle (1-cycle latency); pc_addr >= DEPTH returns 0.
//   load_start=1 -> LOAD_HI next cycle; ptr<=0, csum<=0, load_err<=0. The read in that cycle still completes.
//  LOAD_HI/LOAD_LO/LOAD_CHK: cpu_hold=1, load_ready=1 (combinational from state); instr_out frozen.
//  LOAD_HI: on handshake latch hi byte, csum += byte (mod 256) -> LOAD_LO.
//  LOAD_LO: on handshake mem[ptr] <= {hi, byte}; csum += byte; ptr==DEPTH-1 -> LOAD_CHK else ptr++, -> LOAD_HI.
//  LOAD_CHK: on handshake load_err <= (byte != csum); load_done pulses next cycle; -> RUN.
//   First RUN cycle re-reads mem[pc_addr] so updated word appears one cycle after cpu_hold falls.
//  No handshake (valid=0) -> state holds indefinitely; no timeout.
//  load_start outside RUN ignored. Words are written as received; a checksum error flags but does not roll back.
//  WORD_W>16: byte order is big-endian, WORD_W/8 bytes per word; LOAD_HI/LOAD_LO generalise to a byte counter.
// STRUCTURE
//  Shared header i281_defs.vh: WORD_W default, state encodings (RUN=2'd0, LOAD_HI=2'd1, LOAD_LO=2'd2, LOAD_CHK=2'd3).
//  Sub-module i281_imem_regs: DEPTH x WORD_W register array, async reset to INIT_IMAGE, one write port,
//   one registered read port with out-of-range zeroing. FSM, byte assembly and checksum live in the top.
// TESTING
//  1 Reset, INIT_IMAGE word0=16'h380C, word1=16'h120E; pc_addr 0 then 1 -> instr_out 16'h380C, 16'h120E one cycle later each.
//  2 Download DEPTH=32 words value 16'hA500+i, correct checksum byte -> load_done pulse, load_err 0, read word 5 = 16'hA505.
//  3 Same download with checksum off by 1 -> load_err 1, memory still updated; next load_start clears load_err.
//  4 load_valid toggled 0/1 randomly during download -> identical final memory to test 2; cpu_hold high throughout.
//  5 Assert rst_n=0 after 10 words loaded -> all outputs at reset values, mem[0] reads 16'h380C again.
//  6 load_start pulsed during LOAD_LO and pc_addr=31 with DEPTH=20 -> start ignored; out-of-range read returns 16'h0000.

Source files
------------

// File: rtl/i281_boot_imem_pkg.sv
// Shared types and defaults for the i281 reloadable instruction memory.
// State encodings are fixed so debug taps and scripts can decode them.
package i281_boot_imem_pkg;

    localparam int WORD_W_DEF = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_HI  = 2'd1,
        LOAD_LO  = 2'd2,
        LOAD_CHK = 2'd3
    } state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/i281_imem_regs.sv
// DEPTH x WORD_W register array with async reset to a default image.
// Latency: 1 cycle registered read (held when rd_en=0). Backpressure: none, one write per cycle.
// Out-of-range read addresses return zero.
module i281_imem_regs #(
    parameter int                      WORD_W     = 16,
    parameter int                      DEPTH      = 32,
    parameter int                      ADDR_W     = 5,
    parameter logic [DEPTH*WORD_W-1:0] INIT_IMAGE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_IMAGE[i*WORD_W +: WORD_W];
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= (32'(raddr) < DEPTH) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/i281_boot_imem.sv
// Field-reloadable i281 instruction memory with byte-serial download and trailing checksum.
// Latency: instr_out 1 cycle after pc_addr; reloaded word visible 1 cycle after cpu_hold falls.
// Backpressure: load_ready is high in every load state; a stalled sender just holds the FSM in place.
module i281_boot_imem
    import i281_boot_imem_pkg::*;
#(
    parameter int                      WORD_W     = WORD_W_DEF,
    parameter int                      DEPTH      = 32,
    parameter logic [DEPTH*WORD_W-1:0] INIT_IMAGE = '0,
    localparam int                     ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [WORD_W-1:0] instr_out,
    output logic              cpu_hold,
    input  logic              load_start,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err
);

    localparam int NBYTES = WORD_W / 8;
    localparam int BC_W   = (NBYTES > 2) ? $clog2(NBYTES - 1) : 1;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [7:0]          csum;
    logic [WORD_W-9:0]   asm_q;
    logic [WORD_W-1:0]   asm_nxt;
    logic [BC_W-1:0]     bcnt;
    logic                hs, last_word, last_byte, mem_we, rd_en;

    assign hs        = load_valid & load_ready;
    assign last_word = (32'(ptr) == DEPTH - 1);
    assign last_byte = (32'(bcnt) == NBYTES - 2);
    // Big-endian assembly: earlier bytes shift up, the current byte lands in the low lane.
    assign asm_nxt   = {asm_q, load_data};

    always_comb begin
        state_nxt  = state;
        cpu_hold   = (state != RUN);
        load_ready = (state != RUN);
        rd_en      = (state == RUN);
        mem_we     = 1'b0;
        case (state)
            RUN:      if (load_start) state_nxt = LOAD_HI;
            LOAD_HI:  if (hs && last_byte) state_nxt = LOAD_LO;
            LOAD_LO: begin
                if (hs) begin
                    mem_we    = 1'b1;
                    state_nxt = last_word ? LOAD_CHK : LOAD_HI;
                end
            end
            LOAD_CHK: if (hs) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ptr       <= '0;
            csum      <= '0;
            asm_q     <= '0;
            bcnt      <= '0;
            load_err  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_done <= (state == LOAD_CHK) && hs;
            case (state)
                RUN: begin
                    if (load_start) begin
                        ptr      <= '0;
                        csum     <= '0;
                        bcnt     <= '0;
                        load_err <= 1'b0;
                    end
                end
                LOAD_HI: begin
                    if (hs) begin
                        asm_q <= asm_nxt[WORD_W-9:0];
                        csum  <= csum_add(csum, load_data);
                        bcnt  <= last_byte ? '0 : bcnt + 1'b1;
                    end
                end
                LOAD_LO: begin
                    if (hs) begin
                        csum <= csum_add(csum, load_data);
                        if (!last_word) ptr <= ptr + 1'b1;
                    end
                end
                LOAD_CHK: begin
                    if (hs) load_err <= (load_data != csum);
                end
                default: ;
            endcase
        end
    end

    i281_imem_regs #(
        .WORD_W     (WORD_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .INIT_IMAGE (INIT_IMAGE)
    ) u_regs (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (ptr),
        .wdata (asm_nxt),
        .rd_en (rd_en),
        .raddr (pc_addr),
        .rdata (instr_out)
    );

endmodule

// File: tb/tb_i281_boot_imem.sv
// Scoreboard bench for i281_boot_imem: a DEPTH=32 instance (a) and a DEPTH=20 instance (b).
module tb_i281_boot_imem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  pc_a = '0, pc_b = '0;
    logic        ls_a = 1'b0, ls_b = 1'b0, lv_a = 1'b0, lv_b = 1'b0;
    logic [7:0]  ld_a = '0, ld_b = '0;
    logic [15:0] io_a, io_b;
    logic        hold_a, rdy_a, done_a, err_a;
    logic        hold_b, rdy_b, done_b, err_b;

    localparam logic [32*16-1:0] IMG_A = {{30{16'h0000}}, 16'h120E, 16'h380C};
    localparam logic [20*16-1:0] IMG_B = {16'hBEEF, {19{16'h0000}}};

    i281_boot_imem #(.WORD_W(16), .DEPTH(32), .INIT_IMAGE(IMG_A)) dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_a), .instr_out(io_a), .cpu_hold(hold_a),
        .load_start(ls_a), .load_data(ld_a), .load_valid(lv_a), .load_ready(rdy_a),
        .load_done(done_a), .load_err(err_a)
    );

    i281_boot_imem #(.WORD_W(16), .DEPTH(20), .INIT_IMAGE(IMG_B)) dut20 (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_b), .instr_out(io_b), .cpu_hold(hold_b),
        .load_start(ls_b), .load_data(ld_b), .load_valid(lv_b), .load_ready(rdy_b),
        .load_done(done_b), .load_err(err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // sel: 0 instr_out, 1 cpu_hold, 2 load_ready, 3 load_done, 4 load_err; +8 selects instance b
    typedef struct {
        int          due;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] get_act(input int sel);
        case (sel)
            0:  return io_a;
            1:  return {15'd0, hold_a};
            2:  return {15'd0, rdy_a};
            3:  return {15'd0, done_a};
            4:  return {15'd0, err_a};
            8:  return io_b;
            9:  return {15'd0, hold_b};
            10: return {15'd0, rdy_b};
            11: return {15'd0, done_b};
            12: return {15'd0, err_b};
            default: return 'x;
        endcase
    endfunction

    task automatic push(input int due, input int sel, input logic [15:0] v, input string nm);
        exp_t e;
        e.due = due; e.sel = sel; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [15:0] act;
                act = get_act(sb[i].sel);
                n_cmp++;
                if (sb[i].due < cyc || act !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, required %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic set_pc(input bit b, input logic [4:0] a);
        if (b) pc_b = a; else pc_a = a;
    endtask

    task automatic set_start(input bit b, input logic v);
        if (b) ls_b = v; else ls_a = v;
    endtask

    task automatic set_byte(input bit b, input logic v, input logic [7:0] d);
        if (b) begin lv_b = v; ld_b = d; end
        else   begin lv_a = v; ld_a = d; end
    endtask

    task automatic rd(input bit b, input logic [4:0] a, input logic [15:0] exp, input string nm);
        @(posedge clk); #1;
        set_pc(b, a);
        push(cyc + 1, b ? 8 : 0, exp, nm);
    endtask

    task automatic send_byte(input bit b, input logic [7:0] d, input bit gaps);
        int n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                push(cyc, b ? 9 : 1, 16'd1, "hold_in_gap");
            end
        end
        set_byte(b, 1'b1, d);
        while (!(b ? rdy_b : rdy_a) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n >= 8) begin
            n_bad++;
            $display("FAIL load_ready_timeout: ready=0 after %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        set_byte(b, 1'b0, 8'h00);
    endtask

    task automatic download(input bit b, input int nw, input logic [15:0] base,
                            input logic [7:0] ck, input logic exp_err, input bit gaps,
                            input bit pulse, input logic [4:0] pc0, input logic [15:0] exp0,
                            input logic [4:0] pc1, input logic [15:0] exp1);
        int o = b ? 8 : 0;
        logic [15:0] w;
        @(posedge clk); #1;
        set_start(b, 1'b1);
        set_pc(b, pc0);
        push(cyc + 1, o, exp0, "start_cycle_read");
        @(posedge clk); #1;
        set_start(b, 1'b0);
        set_pc(b, pc1);
        push(cyc, o + 1, 16'd1, "hold_after_start");
        push(cyc, o + 2, 16'd1, "ready_after_start");
        push(cyc, o + 4, 16'd0, "err_cleared_by_start");
        for (int i = 0; i < nw; i++) begin
            w = base + 16'(i);
            send_byte(b, w[15:8], gaps);
            if (pulse && i == 0) begin
                set_start(b, 1'b1);
                @(posedge clk); #1;
                set_start(b, 1'b0);
                push(cyc, o + 1, 16'd1, "hold_after_ignored_start");
            end
            send_byte(b, w[7:0], gaps);
            push(cyc, o, exp0, "instr_frozen");
            push(cyc, o + 1, 16'd1, "hold_during_load");
        end
        send_byte(b, ck, gaps);
        push(cyc, o + 3, 16'd1, "done_pulse");
        push(cyc, o + 1, 16'd0, "hold_released");
        push(cyc, o + 2, 16'd0, "ready_released");
        push(cyc, o + 4, {15'd0, exp_err}, "load_err");
        push(cyc, o, exp0, "instr_first_run_cycle");
        push(cyc + 1, o, exp1, "reread_after_load");
        push(cyc + 1, o + 3, 16'd0, "done_pulse_end");
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset values on both instances
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            push(cyc, k * 8 + 0, 16'h0000, "rst_instr");
            push(cyc, k * 8 + 1, 16'd0, "rst_hold");
            push(cyc, k * 8 + 2, 16'd0, "rst_ready");
            push(cyc, k * 8 + 3, 16'd0, "rst_done");
            push(cyc, k * 8 + 4, 16'd0, "rst_err");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Default image, back-to-back reads
        rd(0, 5'd0, 16'h380C, "init_word0");
        rd(0, 5'd1, 16'h120E, "init_word1");

        // Full download A500+i; checksum = 32*A5 + sum(0..31) = A0 + F0 = 90 (mod 256)
        download(0, 32, 16'hA500, 8'h90, 1'b0, 1'b0, 1'b0, 5'd0, 16'h380C, 5'd5, 16'hA505);
        rd(0, 5'd31, 16'hA51F, "dl_word31");

        // Reset after 10 words restores the default image
        @(posedge clk); #1;
        ls_a = 1'b1;
        @(posedge clk); #1;
        ls_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_byte(0, 8'hA5, 1'b0);
            send_byte(0, 8'(i), 1'b0);
        end
        rst_n = 1'b0;
        push(cyc, 0, 16'h0000, "midrst_instr");
        push(cyc, 1, 16'd0, "midrst_hold");
        push(cyc, 2, 16'd0, "midrst_ready");
        push(cyc, 3, 16'd0, "midrst_done");
        push(cyc, 4, 16'd0, "midrst_err");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(0, 5'd0, 16'h380C, "midrst_word0");
        rd(0, 5'd5, 16'h0000, "midrst_word5");
        rd(0, 5'd1, 16'h120E, "midrst_word1");

        // Bad checksum: error flagged, words still written
        download(0, 32, 16'hA500, 8'h91, 1'b1, 1'b0, 1'b0, 5'd0, 16'h380C, 5'd5, 16'hA505);

        // Random valid gaps; the start clears the sticky error
        download(0, 32, 16'hA500, 8'h90, 1'b0, 1'b1, 1'b0, 5'd0, 16'hA500, 5'd31, 16'hA51F);
        rd(0, 5'd5, 16'hA505, "gap_word5");
        rd(0, 5'd17, 16'hA511, "gap_word17");

        // DEPTH=20: out-of-range reads zero, start during LOAD_LO ignored
        // checksum = 20*5A + sum(0..19) = 08 + BE = C6 (mod 256)
        rd(1, 5'd31, 16'h0000, "d20_oor_before");
        rd(1, 5'd19, 16'hBEEF, "d20_init_word19");
        download(1, 20, 16'h5A00, 8'hC6, 1'b0, 1'b0, 1'b1, 5'd19, 16'hBEEF, 5'd31, 16'h0000);
        rd(1, 5'd19, 16'h5A13, "d20_word19");
        rd(1, 5'd0, 16'h5A00, "d20_word0");

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp += sb.size();
            n_bad += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
